reg_wr_arb: RTL and testbench

REG_WR_ARB -- requirements
Module: reg_wr_arb

---
 rtl/reg_wr_arb.sv | 112 +++++++++++
 tb/tb_reg_wr_arb.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wr_arb.sv
// Two-requester round-robin write arbiter driving a bank of 2**ADDR_W registers, with a synchronous clear path.
// Optional contention counter enabled by defining REG_WR_ARB_COLL_CNT_EN.
module reg_wr_arb #(
  parameter int N      = 32,
  parameter int ADDR_W = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic [ADDR_W-1:0]      a_addr,
  input  logic [N-1:0]           a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [ADDR_W-1:0]      b_addr,
  input  logic [N-1:0]           b_data,
  output logic                   b_ready,
  input  logic                   clr_req,
  output logic [2**ADDR_W-1:0]   wr_en,
  output logic [N-1:0]           wr_data,
  output logic                   reg_clr,
  output logic                   clr_ack,
  output logic [7:0]             coll_cnt
);

  localparam int NUM_REGS = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t                state;
  state_t                next_state;
  logic                  prio_b;
  logic                  a_acc;
  logic                  b_acc;
  logic [ADDR_W-1:0]     sel_addr;
  logic [N-1:0]          sel_data;
  logic [NUM_REGS-1:0]   sel_onehot;
  logic [NUM_REGS-1:0]   wr_en_q;
  logic [N-1:0]          wr_data_q;

  // Grants are combinational; prio_b set means B wins the next contention.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (reset_n && !clr_req) begin
      if (a_valid && b_valid) begin
        a_ready = !prio_b;
        b_ready = prio_b;
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  assign a_acc = a_valid & a_ready;
  assign b_acc = b_valid & b_ready;

  always_comb begin
    sel_addr   = a_acc ? a_addr : b_addr;
    sel_data   = a_acc ? a_data : b_data;
    sel_onehot = '0;
    sel_onehot[sel_addr] = 1'b1;
  end

  always_comb begin
    next_state = IDLE;
    if (clr_req) begin
      next_state = CLEAR;
    end else if (a_acc || b_acc) begin
      next_state = WRITE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      prio_b    <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == WRITE) begin
        wr_en_q   <= sel_onehot;
        wr_data_q <= sel_data;
        prio_b    <= a_acc;
      end
    end
  end

  // Gating with reset_n kills a write pulse whose cycle coincides with reset assertion.
  assign wr_en   = (state == WRITE && reset_n) ? wr_en_q : '0;
  assign wr_data = wr_data_q;
  assign reg_clr = (state == CLEAR) && reset_n;
  assign clr_ack = (state == CLEAR) && reset_n;

`ifdef REG_WR_ARB_COLL_CNT_EN
  logic [7:0] coll_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clr_req) begin
      coll_q <= '0;
    end else if (a_valid && b_valid && coll_q != 8'hFF) begin
      coll_q <= coll_q + 8'd1;
    end
  end

  assign coll_cnt = coll_q;
`else
  assign coll_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_wr_arb.sv
// Self-checking bench for reg_wr_arb: directed vector table, reset-abort sequence, and randomized run vs. a rule-level model.
module tb_reg_wr_arb;

  localparam int N      = 32;
  localparam int ADDR_W = 2;
`ifdef REG_WR_ARB_COLL_CNT_EN
  localparam logic [7:0] C = 8'd1;
  localparam bit CNT_ON = 1'b1;
`else
  localparam logic [7:0] C = 8'd0;
  localparam bit CNT_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              a_valid = 1'b0;
  logic [1:0]        a_addr = '0;
  logic [31:0]       a_data = '0;
  logic              a_ready;
  logic              b_valid = 1'b0;
  logic [1:0]        b_addr = '0;
  logic [31:0]       b_data = '0;
  logic              b_ready;
  logic              clr_req = 1'b0;
  logic [3:0]        wr_en;
  logic [31:0]       wr_data;
  logic              reg_clr;
  logic              clr_ack;
  logic [7:0]        coll_cnt;

  int errors = 0;
  int checks = 0;

  reg_wr_arb #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .clr_req(clr_req), .wr_en(wr_en), .wr_data(wr_data),
    .reg_clr(reg_clr), .clr_ack(clr_ack), .coll_cnt(coll_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic        clr;
    logic        av;
    logic [1:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [1:0]  ba;
    logic [31:0] bd;
    logic        e_ar;
    logic        e_br;
    logic [3:0]  e_wr_en;
    logic [31:0] e_wr_data;
    logic        e_clr;
    logic [7:0]  e_coll;
  } vec_t;

  vec_t tbl [17];

  // Reference model: who gets served follows the arbitration rules; outputs are what the write bus shows next cycle.
  bit          m_prio_b;
  bit          m_ra;
  bit          m_rb;
  logic [3:0]  m_wr_en;
  logic [31:0] m_wr_data;
  logic        m_reg_clr;
  logic [7:0]  m_coll;

  function automatic void model_ready();
    m_ra = 1'b0;
    m_rb = 1'b0;
    if (reset_n && !clr_req) begin
      if (a_valid && b_valid) begin
        m_ra = !m_prio_b;
        m_rb = m_prio_b;
      end else begin
        m_ra = a_valid;
        m_rb = b_valid;
      end
    end
  endfunction

  function automatic void model_edge();
    if (!reset_n) begin
      m_wr_en = 4'h0; m_wr_data = 32'h0; m_reg_clr = 1'b0; m_prio_b = 1'b0; m_coll = 8'h0;
    end else if (clr_req) begin
      m_wr_en = 4'h0; m_reg_clr = 1'b1; m_coll = 8'h0;
    end else begin
      m_reg_clr = 1'b0;
      if (m_ra) begin
        m_wr_en = 4'h1 << a_addr; m_wr_data = a_data; m_prio_b = 1'b1;
      end else if (m_rb) begin
        m_wr_en = 4'h1 << b_addr; m_wr_data = b_data; m_prio_b = 1'b0;
      end else begin
        m_wr_en = 4'h0;
      end
      if (CNT_ON && a_valid && b_valid && m_coll < 8'd255) m_coll = m_coll + 8'd1;
    end
  endfunction

  task automatic applyStimulus(input logic rst, input logic clr,
                               input logic av, input logic [1:0] aa, input logic [31:0] ad,
                               input logic bv, input logic [1:0] ba, input logic [31:0] bd);
    @(negedge clk);
    reset_n = rst; clr_req = clr;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_vs_model(input string tag);
    checkOutput({tag, " wr_en"}, {28'h0, wr_en}, {28'h0, m_wr_en});
    checkOutput({tag, " wr_data"}, wr_data, m_wr_data);
    checkOutput({tag, " reg_clr"}, {31'h0, reg_clr}, {31'h0, m_reg_clr});
    checkOutput({tag, " clr_ack"}, {31'h0, clr_ack}, {31'h0, m_reg_clr});
    checkOutput({tag, " coll_cnt"}, {24'h0, coll_cnt}, {24'h0, m_coll});
  endtask

  initial begin
    logic       av_r, bv_r;
    logic [1:0] aa_r, ba_r;
    logic [31:0] ad_r, bd_r;
    logic       a_acc, b_acc;

    m_prio_b = 1'b0; m_wr_en = '0; m_wr_data = '0; m_reg_clr = 1'b0; m_coll = '0;

    //            rst   clr   av    aa    ad            bv    ba    bd          ar    br    wr_en  wr_data       clr   coll
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0,        1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 8'h0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 4'h4, 32'hDEADBEEF, 1'b0, 8'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 4'h0, 32'hDEADBEEF, 1'b0, 8'h0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,        1'b0, 8'h0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h1,        1'b1, 2'd3, 32'h2,  1'b1, 1'b0, 4'h1, 32'h1,        1'b0, C};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        1'b1, 2'd3, 32'h2,  1'b0, 1'b1, 4'h8, 32'h2,        1'b0, C};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h10,       1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 4'h1, 32'h10,       1'b0, C};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 2'd1, 32'h11,       1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 4'h2, 32'h11,       1'b0, C};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 2'd2, 32'h12,       1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 4'h4, 32'h12,       1'b0, C};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 2'd3, 32'h13,       1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 4'h8, 32'h13,       1'b0, C};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 2'd1, 32'hAA,       1'b1, 2'd2, 32'hBB, 1'b0, 1'b0, 4'h0, 32'h13,       1'b1, 8'h0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 2'd1, 32'hAA,       1'b1, 2'd2, 32'hBB, 1'b0, 1'b1, 4'h4, 32'hBB,       1'b0, C};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 32'hAA,       1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 4'h2, 32'hAA,       1'b0, C};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h55,       1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 4'h1, 32'h55,       1'b0, C};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h55,       1'b1, 8'h0};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 2'd3, 32'h77,       1'b0, 2'd0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h55,       1'b1, 8'h0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 2'd3, 32'h77,       1'b0, 2'd0, 32'h0,  1'b1, 1'b0, 4'h8, 32'h77,       1'b0, 8'h0};

    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].rst_n, tbl[i].clr, tbl[i].av, tbl[i].aa, tbl[i].ad,
                    tbl[i].bv, tbl[i].ba, tbl[i].bd);
      #1;
      checkOutput($sformatf("vec%0d a_ready", i), {31'h0, a_ready}, {31'h0, tbl[i].e_ar});
      checkOutput($sformatf("vec%0d b_ready", i), {31'h0, b_ready}, {31'h0, tbl[i].e_br});
      model_ready();
      @(posedge clk);
      model_edge();
      #1;
      checkOutput($sformatf("vec%0d wr_en", i), {28'h0, wr_en}, {28'h0, tbl[i].e_wr_en});
      checkOutput($sformatf("vec%0d wr_data", i), wr_data, tbl[i].e_wr_data);
      checkOutput($sformatf("vec%0d reg_clr", i), {31'h0, reg_clr}, {31'h0, tbl[i].e_clr});
      checkOutput($sformatf("vec%0d clr_ack", i), {31'h0, clr_ack}, {31'h0, tbl[i].e_clr});
      checkOutput($sformatf("vec%0d coll_cnt", i), {24'h0, coll_cnt}, {24'h0, tbl[i].e_coll});
    end

    // Write accepted, then reset asserted during the cycle its pulse would appear.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 32'h99, 1'b0, 2'd0, 32'h0);
    #1;
    checkOutput("abort a_ready", {31'h0, a_ready}, 32'h1);
    model_ready();
    @(posedge clk);
    model_edge();
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("abort no wr_en pulse", {28'h0, wr_en}, 32'h0);
    checkOutput("abort reg_clr", {31'h0, reg_clr}, 32'h0);
    checkOutput("abort a_ready in reset", {31'h0, a_ready}, 32'h0);
    model_ready();
    @(posedge clk);
    model_edge();
    #1;
    checkOutput("abort wr_en", {28'h0, wr_en}, 32'h0);
    checkOutput("abort wr_data", wr_data, 32'h0);
    checkOutput("abort clr_ack", {31'h0, clr_ack}, 32'h0);
    checkOutput("abort coll_cnt", {24'h0, coll_cnt}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 32'h5, 1'b1, 2'd3, 32'h6);
    #1;
    checkOutput("abort ptr a_ready", {31'h0, a_ready}, 32'h1);
    checkOutput("abort ptr b_ready", {31'h0, b_ready}, 32'h0);
    model_ready();
    @(posedge clk);
    model_edge();
    #1;
    checkOutput("abort ptr wr_en", {28'h0, wr_en}, 32'h1);
    checkOutput("abort ptr wr_data", wr_data, 32'h5);

    // Randomized traffic; requesters hold their request until the model says it was served.
    av_r = 1'b0; bv_r = 1'b0; aa_r = '0; ba_r = '0; ad_r = '0; bd_r = '0;
    a_acc = 1'b1; b_acc = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (!av_r || a_acc) begin
        av_r = 1'($urandom_range(0, 1)); aa_r = 2'($urandom_range(0, 3)); ad_r = $urandom;
      end
      if (!bv_r || b_acc) begin
        bv_r = 1'($urandom_range(0, 1)); ba_r = 2'($urandom_range(0, 3)); bd_r = $urandom;
      end
      applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 11) == 0),
                    av_r, aa_r, ad_r, bv_r, ba_r, bd_r);
      #1;
      model_ready();
      checkOutput($sformatf("rand%0d a_ready", k), {31'h0, a_ready}, {31'h0, m_ra});
      checkOutput($sformatf("rand%0d b_ready", k), {31'h0, b_ready}, {31'h0, m_rb});
      a_acc = av_r && m_ra;
      b_acc = bv_r && m_rb;
      @(posedge clk);
      model_edge();
      #1;
      check_vs_model($sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
